// File: rtl/l1_ld_fill_ctrl_if.sv
// l1_ld_fill_ctrl_if
// Bundles the handshake and bus signals of the L1 load-miss line fill
// controller so that the controller and its environment share one port.
//
// Signals (direction seen from the controller, modport "slave"):
//   MEM_READY  in   data memory init complete, writes permitted when high
//   REQ_VAL    in   fill request from the miss handler
//   REQ_ADDR   in   missing word address, low BW bits are the critical offset
//   REQ_RDY    out  controller accepts a request
//   BEAT_VAL   in   refill beat valid from next-level memory
//   BEAT_DATA  in   refill beat data, critical word first
//   BEAT_RDY   out  controller accepts a beat
//   WEN        out  data memory write enable
//   WADDR      out  data memory write address
//   WDATA      out  data memory write data
//   CRIT_VAL   out  one-cycle pulse carrying the critical word to the core
//   CRIT_DATA  out  critical word data
//   FILL_DONE  out  one-cycle pulse after the last line word is written
// The "master" modport is the mirror image, used by whatever drives the
// controller (miss handler / refill path / testbench).
interface l1_ld_fill_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 10
);
  logic             MEM_READY;
  logic             REQ_VAL;
  logic [AW-1:0]    REQ_ADDR;
  logic             REQ_RDY;
  logic             BEAT_VAL;
  logic [WIDTH-1:0] BEAT_DATA;
  logic             BEAT_RDY;
  logic             WEN;
  logic [AW-1:0]    WADDR;
  logic [WIDTH-1:0] WDATA;
  logic             CRIT_VAL;
  logic [WIDTH-1:0] CRIT_DATA;
  logic             FILL_DONE;

  modport master (
    output MEM_READY, REQ_VAL, REQ_ADDR, BEAT_VAL, BEAT_DATA,
    input  REQ_RDY, BEAT_RDY, WEN, WADDR, WDATA, CRIT_VAL, CRIT_DATA, FILL_DONE
  );

  modport slave (
    input  MEM_READY, REQ_VAL, REQ_ADDR, BEAT_VAL, BEAT_DATA,
    output REQ_RDY, BEAT_RDY, WEN, WADDR, WDATA, CRIT_VAL, CRIT_DATA, FILL_DONE
  );
endinterface

// File: rtl/l1_ld_fill_ctrl.sv
// l1_ld_fill_ctrl
// L1 data cache load-miss line fill controller. Accepts one fill request,
// then writes BEATS refill beats into the data memory starting at the
// critical word and wrapping within the line. The first beat is also
// forwarded to the core as the critical word.
//
// Ports:
//   CLK  single clock, all state updates on its rising edge
//   RST  synchronous active-high reset
//   bus  l1_ld_fill_ctrl_if.slave (request, refill beat, memory write,
//        critical word and fill-done signals)
//
// Parameters:
//   WIDTH  data word width in bits
//   DEPTH  data memory depth in words, AW = $clog2(DEPTH)
//   BEATS  words per line (power of 2, at least 2), BW = $clog2(BEATS)
module l1_ld_fill_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int BEATS = 4
) (
  input  logic              CLK,
  input  logic              RST,
  l1_ld_fill_ctrl_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;

  logic             mem_ready_q;
  logic [BW-1:0]    cnt;
  logic [BW-1:0]    offset;
  logic [AW-1:0]    base;
  logic [BW-1:0]    line_idx;

  logic             wen_q;
  logic [AW-1:0]    waddr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             crit_val_q;
  logic [WIDTH-1:0] crit_data_q;
  logic             fill_done_q;

  logic             req_rdy;
  logic             beat_rdy;
  logic             req_acc;
  logic             beat_acc;
  logic             fill_done_d;

  // Offset + beat count in BW bits wraps inside the line by construction.
  assign line_idx = offset + cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= INIT;
    end else begin
      state <= next_state;
    end
  end

  // DONE lasts two cycles: the first carries the final write (registered
  // from the last acceptance), the second carries FILL_DONE. Leaving DONE
  // only after FILL_DONE puts REQ_RDY one cycle behind the pulse.
  // INIT waits on the registered MEM_READY sample, so IDLE is reached two
  // cycles after MEM_READY rises.
  always_comb begin
    next_state  = state;
    req_rdy     = 1'b0;
    beat_rdy    = 1'b0;
    req_acc     = 1'b0;
    beat_acc    = 1'b0;
    fill_done_d = 1'b0;
    case (state)
      INIT: begin
        if (mem_ready_q) begin
          next_state = IDLE;
        end
      end
      IDLE: begin
        req_rdy = 1'b1;
        if (bus.REQ_VAL) begin
          req_acc    = 1'b1;
          next_state = FILL;
        end
      end
      FILL: begin
        beat_rdy = 1'b1;
        if (bus.BEAT_VAL) begin
          beat_acc = 1'b1;
          if (cnt == LAST_BEAT) begin
            next_state = DONE;
          end
        end
      end
      DONE: begin
        if (fill_done_q) begin
          next_state = IDLE;
        end else begin
          fill_done_d = 1'b1;
        end
      end
      default: begin
        next_state = INIT;
      end
    endcase
  end

  // Request capture, beat counting and the registered write / critical
  // word outputs. WADDR, WDATA and CRIT_DATA hold their last value when
  // no write is in progress.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_ready_q <= 1'b0;
      cnt         <= '0;
      offset      <= '0;
      base        <= '0;
      wen_q       <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      crit_val_q  <= 1'b0;
      crit_data_q <= '0;
      fill_done_q <= 1'b0;
    end else begin
      mem_ready_q <= bus.MEM_READY;
      wen_q       <= beat_acc;
      crit_val_q  <= beat_acc && (cnt == '0);
      fill_done_q <= fill_done_d;
      if (req_acc) begin
        base   <= {bus.REQ_ADDR[AW-1:BW], {BW{1'b0}}};
        offset <= bus.REQ_ADDR[BW-1:0];
        cnt    <= '0;
      end
      if (beat_acc) begin
        cnt     <= cnt + 1'b1;
        waddr_q <= base | {{(AW-BW){1'b0}}, line_idx};
        wdata_q <= bus.BEAT_DATA;
        if (cnt == '0) begin
          crit_data_q <= bus.BEAT_DATA;
        end
      end
    end
  end

  assign bus.REQ_RDY   = req_rdy;
  assign bus.BEAT_RDY  = beat_rdy;
  assign bus.WEN       = wen_q;
  assign bus.WADDR     = waddr_q;
  assign bus.WDATA     = wdata_q;
  assign bus.CRIT_VAL  = crit_val_q;
  assign bus.CRIT_DATA = crit_data_q;
  assign bus.FILL_DONE = fill_done_q;

endmodule

// File: tb/tb_l1_ld_fill_ctrl.sv
// tb_l1_ld_fill_ctrl
// Directed self-checking bench for l1_ld_fill_ctrl with default parameters
// (WIDTH=32, DEPTH=1024, BEATS=4). Inputs are driven 1 time unit after each
// rising edge; outputs are checked at the same point, i.e. the values that
// hold for the whole cycle. Expected addresses are written out by hand.
module tb_l1_ld_fill_ctrl;

  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
  localparam int BEATS = 4;
  localparam int AW    = 10;

  logic clk = 1'b0;
  logic rst;

  int total = 0;
  int bad   = 0;

  l1_ld_fill_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  l1_ld_fill_ctrl #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .BEATS(BEATS)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rv, input logic [AW-1:0] ra,
                               input logic bv, input logic [WIDTH-1:0] bd);
    bus.REQ_VAL   = rv;
    bus.REQ_ADDR  = ra;
    bus.BEAT_VAL  = bv;
    bus.BEAT_DATA = bd;
  endtask

  // One complete line fill starting in an IDLE cycle and ending in the
  // IDLE cycle that follows FILL_DONE. gap = idle cycles between beats,
  // hold = keep REQ_VAL high throughout.
  task automatic runFill(input logic [AW-1:0] addr, input int gap, input bit hold,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                         input logic [WIDTH-1:0] seed);
    logic [AW-1:0] exp_a [4];
    logic [WIDTH-1:0] d;
    exp_a = '{a0, a1, a2, a3};
    checkOutput("idle_req_rdy", bus.REQ_RDY, 1);
    applyStimulus(1'b1, addr, 1'b0, '0);
    step();
    if (!hold) bus.REQ_VAL = 1'b0;
    checkOutput("fill_req_rdy", bus.REQ_RDY, 0);
    checkOutput("fill_beat_rdy", bus.BEAT_RDY, 1);
    checkOutput("fill_wen_idle", bus.WEN, 0);
    for (int n = 0; n < 4; n++) begin
      d = seed + WIDTH'(n);
      bus.BEAT_VAL  = 1'b1;
      bus.BEAT_DATA = d;
      step();
      bus.BEAT_VAL = 1'b0;
      checkOutput($sformatf("wen_b%0d", n), bus.WEN, 1);
      checkOutput($sformatf("waddr_b%0d", n), bus.WADDR, exp_a[n]);
      checkOutput($sformatf("wdata_b%0d", n), bus.WDATA, d);
      checkOutput($sformatf("crit_val_b%0d", n), bus.CRIT_VAL, (n == 0) ? 1 : 0);
      if (n == 0) checkOutput("crit_data", bus.CRIT_DATA, d);
      if (n < 3) begin
        for (int g = 0; g < gap; g++) begin
          step();
          checkOutput($sformatf("gap_wen_b%0d", n), bus.WEN, 0);
        end
      end
    end
    checkOutput("last_write_fill_done", bus.FILL_DONE, 0);
    checkOutput("last_write_beat_rdy", bus.BEAT_RDY, 0);
    step();
    checkOutput("fill_done_pulse", bus.FILL_DONE, 1);
    checkOutput("fill_done_wen", bus.WEN, 0);
    checkOutput("fill_done_req_rdy", bus.REQ_RDY, 0);
    step();
    checkOutput("after_done_pulse", bus.FILL_DONE, 0);
    checkOutput("after_done_req_rdy", bus.REQ_RDY, 1);
  endtask

  initial begin
    rst = 1'b1;
    bus.MEM_READY = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0);
    repeat (3) step();

    // Reset state
    checkOutput("rst_req_rdy", bus.REQ_RDY, 0);
    checkOutput("rst_beat_rdy", bus.BEAT_RDY, 0);
    checkOutput("rst_wen", bus.WEN, 0);
    checkOutput("rst_crit_val", bus.CRIT_VAL, 0);
    checkOutput("rst_fill_done", bus.FILL_DONE, 0);
    checkOutput("rst_waddr", bus.WADDR, 0);
    checkOutput("rst_wdata", bus.WDATA, 0);
    checkOutput("rst_crit_data", bus.CRIT_DATA, 0);

    // Init gating: request pending while memory is not ready
    rst = 1'b0;
    applyStimulus(1'b1, 10'h155, 1'b0, '0);
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("init_req_rdy", bus.REQ_RDY, 0);
      checkOutput("init_beat_rdy", bus.BEAT_RDY, 0);
    end
    bus.MEM_READY = 1'b1;
    bus.REQ_VAL   = 1'b0;
    step();
    checkOutput("init_ready_plus1", bus.REQ_RDY, 0);
    step();
    checkOutput("init_ready_plus2", bus.REQ_RDY, 1);

    // Stray beats in IDLE cause no writes
    applyStimulus(1'b0, '0, 1'b1, 32'hDEAD_BEEF);
    step();
    checkOutput("stray_wen1", bus.WEN, 0);
    checkOutput("stray_beat_rdy", bus.BEAT_RDY, 0);
    step();
    checkOutput("stray_wen2", bus.WEN, 0);
    bus.BEAT_VAL = 1'b0;

    $display("[TB] aligned fill");
    runFill(10'h100, 0, 1'b0, 10'h100, 10'h101, 10'h102, 10'h103, 32'hA000_0000);

    $display("[TB] wrapped critical-word fill");
    runFill(10'h10E, 0, 1'b0, 10'h10E, 10'h10F, 10'h10C, 10'h10D, 32'hB000_0010);

    $display("[TB] fill with 3-cycle bubbles");
    runFill(10'h2C5, 3, 1'b0, 10'h2C5, 10'h2C6, 10'h2C7, 10'h2C4, 32'hC000_0020);

    $display("[TB] request held through fill");
    runFill(10'h200, 0, 1'b1, 10'h200, 10'h201, 10'h202, 10'h203, 32'hD000_0030);
    runFill(10'h203, 0, 1'b0, 10'h203, 10'h200, 10'h201, 10'h202, 32'hE000_0040);

    $display("[TB] reset mid-fill");
    applyStimulus(1'b1, 10'h041, 1'b0, '0);
    step();
    applyStimulus(1'b0, 10'h041, 1'b1, 32'h1111_0000);
    step();
    checkOutput("mid_wen_b0", bus.WEN, 1);
    bus.BEAT_DATA = 32'h1111_0001;
    step();
    checkOutput("mid_wen_b1", bus.WEN, 1);
    checkOutput("mid_waddr_b1", bus.WADDR, 10'h042);
    rst = 1'b1;
    bus.BEAT_DATA = 32'h1111_0002;
    step();
    checkOutput("mid_rst_wen", bus.WEN, 0);
    checkOutput("mid_rst_beat_rdy", bus.BEAT_RDY, 0);
    checkOutput("mid_rst_req_rdy", bus.REQ_RDY, 0);
    checkOutput("mid_rst_waddr", bus.WADDR, 0);
    rst = 1'b0;
    bus.BEAT_VAL  = 1'b0;
    bus.MEM_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("mid_init_req_rdy", bus.REQ_RDY, 0);
      checkOutput("mid_init_wen", bus.WEN, 0);
      checkOutput("mid_init_fill_done", bus.FILL_DONE, 0);
    end
    bus.MEM_READY = 1'b1;
    step();
    checkOutput("mid_ready_plus1", bus.REQ_RDY, 0);
    step();
    checkOutput("mid_ready_plus2", bus.REQ_RDY, 1);

    $display("[TB] fill at top of memory after reset");
    runFill(10'h3FD, 0, 1'b0, 10'h3FD, 10'h3FE, 10'h3FF, 10'h3FC, 32'hF000_0050);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
